// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types and helpers for the zion basic circuit library.
// Holds the skid-buffer state encoding and a saturating incrementer.
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_e;

  // Saturating +1 on the low 'width' bits of val; counters wider than 32 bits are out of scope.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_skid_dff_if.sv
// Valid/ready channel seen by the skid register slice: upstream and downstream handshakes.
// slave = the slice itself, master = the environment driving it.
interface zion_basic_circuit_lib_skid_dff_if #(
  parameter int WIDTH = 8
);
  logic             iVld;
  logic             oRdy;
  logic [WIDTH-1:0] iDat;
  logic             oVld;
  logic             iRdy;
  logic [WIDTH-1:0] oDat;

  modport slave (
    input  iVld, iDat, iRdy,
    output oRdy, oVld, oDat
  );

  modport master (
    output iVld, iDat, iRdy,
    input  oRdy, oVld, oDat
  );
endinterface

// File: rtl/zion_basic_circuit_lib_sync_en_dff.sv
// D flip-flop bank with enable and synchronous active-high reset to INI_DATA.
module zion_basic_circuit_lib_sync_en_dff #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  // NOTE: data registers are reset too, so oDat shows a known INI_DATA instead of X after reset.
  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) data_q <= INI_DATA;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/zion_basic_circuit_lib_skid_dff.sv
// Valid/ready register slice with a 2-entry skid buffer; all outputs come straight from flops.
// Optional stall counter port oStallCnt is enabled by defining ZION_SKID_DFF_STALL_CNT_EN.
module zion_basic_circuit_lib_skid_dff
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INI_DATA  = '0,
  parameter int               CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  zion_basic_circuit_lib_skid_dff_if.slave bus
`ifdef ZION_SKID_DFF_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]          oStallCnt
`endif
);

  if (WIDTH < 1) begin : g_bad_width
    $error("zion_basic_circuit_lib_skid_dff: WIDTH must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("zion_basic_circuit_lib_skid_dff: CNT_WIDTH must be >= 1");
  end

  skid_state_e      state_q, state_d;
  logic             vld_q, vld_d;
  logic             rdy_q, rdy_d;
  logic             up_acc;
  logic             out_en;
  logic             skid_en;
  logic             out_sel_skid;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    out_en       = 1'b0;
    skid_en      = 1'b0;
    out_sel_skid = 1'b0;
    up_acc       = bus.iVld && rdy_q;
    unique case (state_q)
      EMPTY: begin
        if (up_acc) begin
          out_en  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (up_acc && bus.iRdy) begin
          out_en = 1'b1;
        end else if (up_acc) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (bus.iRdy) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (bus.iRdy) begin
          out_en       = 1'b1;
          out_sel_skid = 1'b1;
          state_d      = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Both handshake outputs are registered copies of decodes of the next state.
    vld_d = (state_d != EMPTY);
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign out_d = out_sel_skid ? skid_q : bus.iDat;

  zion_basic_circuit_lib_sync_en_dff #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI_DATA)
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .en  (out_en),
    .d   (out_d),
    .q   (out_q)
  );

  zion_basic_circuit_lib_sync_en_dff #(
    .WIDTH    (WIDTH),
    .INI_DATA (INI_DATA)
  ) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (bus.iDat),
    .q   (skid_q)
  );

  assign bus.oVld = vld_q;
  assign bus.oRdy = rdy_q;
  assign bus.oDat = out_q;

`ifdef ZION_SKID_DFF_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (vld_q && !bus.iRdy)
      stall_cnt_d = CNT_WIDTH'(sat_inc(32'(stall_cnt_q), CNT_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign oStallCnt = stall_cnt_q;
`endif

endmodule
